// File: rtl/debounce_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debounce_multi                                               |
// | Description : Per-channel 2-flop synchroniser, saturating up/down          |
// |               integrator and hysteresis level with optional edge pulses.   |
// |               Optional feature macro: DEBOUNCE_EDGE_EN (rise/fall pulses). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module debounce_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_MAX  = 1000000,
  parameter int HI_TH    = 750000,
  parameter int LO_TH    = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] c_cnt_max = CW'(CNT_MAX);
  localparam logic [CW-1:0] c_hi      = CW'(HI_TH);
  localparam logic [CW-1:0] c_lo      = CW'(LO_TH);
  localparam logic [CW-1:0] c_one     = CW'(1);
  localparam logic [CW-1:0] c_zero    = CW'(0);

  localparam logic [0:0] c_st_low  = 1'b0;
  localparam logic [0:0] c_st_high = 1'b1;

  if (!((LO_TH >= 0) && (LO_TH < HI_TH) && (HI_TH <= CNT_MAX))) begin : g_param_check
    $error("debounce_multi: need 0 <= LO_TH < HI_TH <= CNT_MAX");
  end

  logic [CHANNELS-1:0] s1_q;
  logic [CHANNELS-1:0] s2_q;
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] level_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
    end
  end

  // Level decisions use the registered count, giving one cycle behind the integrator.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s2_q[i]) begin
        if (cnt_q[i] < c_cnt_max) cnt_d[i] = cnt_q[i] + c_one;
      end else if (cnt_q[i] > c_zero) begin
        cnt_d[i] = cnt_q[i] - c_one;
      end

      case (level_q[i])
        c_st_low: if (cnt_q[i] >= c_hi) level_d[i] = c_st_high;
        default:  if (cnt_q[i] <= c_lo) level_d[i] = c_st_low;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      level_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

`ifdef DEBOUNCE_EDGE_EN
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;

  // Pulses register on the same edge as the level change they report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= level_d & ~level_q;
      fall_q <= ~level_d & level_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
`default_nettype wire
